// File: rtl/ram_burst_pkg.sv
// Shared types and constants for the RAM burst reader and its output FIFO.
package ram_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH     = 4;
    localparam int RD_LATENCY     = 1;
    // One stage for the address register, plus one per RAM read-latency cycle.
    localparam int INFLIGHT_DEPTH = RD_LATENCY + 1;

endpackage

// File: rtl/ram_burst_reader_if.sv
// Request, RAM read port and output stream of the burst reader, bundled together.
interface ram_burst_reader_if #(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 4
);
    logic               start;
    logic [A_WIDTH-1:0] start_address;
    logic [A_WIDTH:0]   burst_len;
    logic               busy;
    logic               done;
    logic [A_WIDTH-1:0] address_read;
    logic [D_WIDTH-1:0] data_read;
    logic [D_WIDTH-1:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;

    modport slave (
        input  start, start_address, burst_len, data_read, out_ready,
        output busy, done, address_read, out_data, out_valid, out_last
    );

    modport master (
        output start, start_address, burst_len, data_read, out_ready,
        input  busy, done, address_read, out_data, out_valid, out_last
    );
endinterface

// File: rtl/ram_burst_reader_fifo.sv
// Small first-word-fall-through FIFO; head data reads as zero while empty.
module burst_fifo
    import ram_burst_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);
    localparam int PTR_W = $clog2(DEPTH);

    // Pointers wrap naturally, so DEPTH must be a power of two.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_count    = r_count;
    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == (PTR_W+1)'(DEPTH));
    assign w_pop_ok   = i_pop && !o_empty;
    assign w_push_ok  = i_push && (!o_full || w_pop_ok);
    assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(i_push && o_full && !w_pop_ok));
        end
    end

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read master: issues addresses to a 1-cycle-latency RAM and streams the
// returned words out in address order under valid/ready backpressure.
module ram_burst_reader
    import ram_burst_pkg::*;
#(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 4,
    parameter int A_MAX   = 16
) (
    input  logic          clk,
    input  logic          reset,
    ram_burst_reader_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = $clog2(FIFO_DEPTH + INFLIGHT_DEPTH + 1);
    localparam logic [A_WIDTH:0]   LEN_MAX   = (A_WIDTH+1)'(A_MAX);
    localparam logic [A_WIDTH-1:0] ADDR_LAST = A_WIDTH'(A_MAX - 1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [A_WIDTH-1:0]        r_addr;
    logic [A_WIDTH-1:0]        w_addr_next;
    logic [A_WIDTH-1:0]        w_addr_inc;
    logic [A_WIDTH:0]          r_remaining;
    logic [A_WIDTH:0]          w_remaining_next;
    logic [A_WIDTH:0]          w_len_clamped;
    logic [INFLIGHT_DEPTH-1:0] r_pipe_valid;
    logic [INFLIGHT_DEPTH-1:0] r_pipe_last;
    logic                      r_done;
    logic                      w_done_next;
    logic                      w_issue;
    logic                      w_issue_last;
    logic [SUM_W-1:0]          w_inflight;
    logic                      w_credit;

    logic                      w_push;
    logic [D_WIDTH:0]          w_push_data;
    logic                      w_pop;
    logic [D_WIDTH:0]          w_pop_data;
    logic [CNT_W-1:0]          w_count;
    logic                      w_empty;
    logic                      w_full;

    assign w_len_clamped = (bus.burst_len > LEN_MAX) ? LEN_MAX : bus.burst_len;
    assign w_addr_inc    = (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;

    // Oldest pipeline stage holds the word the RAM is presenting this cycle.
    assign w_push      = r_pipe_valid[INFLIGHT_DEPTH-1];
    assign w_push_data = {r_pipe_last[INFLIGHT_DEPTH-1], bus.data_read};
    assign w_pop       = !w_empty && bus.out_ready;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < INFLIGHT_DEPTH; i++) begin
            w_inflight = w_inflight + SUM_W'(r_pipe_valid[i]);
        end
    end

    // Registered counts only: a same-cycle pop does not free credit.
    assign w_credit = (SUM_W'(w_count) + w_inflight) < SUM_W'(FIFO_DEPTH);

    always_comb begin
        w_state_next     = r_state;
        w_addr_next      = r_addr;
        w_remaining_next = r_remaining;
        w_issue          = 1'b0;
        w_issue_last     = 1'b0;
        w_done_next      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (w_len_clamped == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_issue          = 1'b1;
                        w_issue_last     = (w_len_clamped == (A_WIDTH+1)'(1));
                        w_addr_next      = bus.start_address;
                        w_remaining_next = w_len_clamped - 1'b1;
                        w_state_next     = w_issue_last ? DRAIN : ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (w_credit) begin
                    w_issue          = 1'b1;
                    w_addr_next      = w_addr_inc;
                    w_remaining_next = r_remaining - 1'b1;
                    if (r_remaining == (A_WIDTH+1)'(1)) begin
                        w_issue_last = 1'b1;
                        w_state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Finish on the edge that consumes the final word.
                if ((r_pipe_valid == '0) &&
                    (w_empty || ((w_count == CNT_W'(1)) && w_pop))) begin
                    w_done_next  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_pipe_valid <= '0;
            r_pipe_last  <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_addr       <= w_addr_next;
            r_remaining  <= w_remaining_next;
            r_pipe_valid <= {r_pipe_valid[INFLIGHT_DEPTH-2:0], w_issue};
            r_pipe_last  <= {r_pipe_last[INFLIGHT_DEPTH-2:0], w_issue_last};
            r_done       <= w_done_next;
        end
    end

    burst_fifo #(
        .WIDTH (D_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_data),
        .o_count     (w_count),
        .o_empty     (w_empty),
        .o_full      (w_full)
    );

    assign bus.busy         = (r_state != IDLE);
    assign bus.done         = r_done;
    assign bus.address_read = r_addr;
    assign bus.out_valid    = !w_empty;
    assign bus.out_data     = w_pop_data[D_WIDTH-1:0];
    assign bus.out_last     = w_pop_data[D_WIDTH] && !w_empty;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench for ram_burst_reader with a behavioural 32x8 RAM (mem[i]=i^A0).
module tb_ram_burst_reader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ram_burst_reader_if #(.D_WIDTH(8), .A_WIDTH(5)) bus ();

    ram_burst_reader #(.D_WIDTH(8), .A_WIDTH(5), .A_MAX(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Stand-in for ram_new: registered read, one clk of latency.
    logic [7:0] mem [32];
    always @(posedge clk) bus.data_read <= mem[bus.address_read];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_hs_cyc = -1;
    int first_valid_cyc = -1;
    int hs_total = 0;
    int ready_mode = 0;
    int pat_idx = 0;
    bit rdy_block = 1'b0;
    logic [8:0] exp_q [$];
    logic [8:0] exp_w;
    logic ready_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    always @(posedge clk) begin
        #1;
        if (rdy_block) begin
            bus.out_ready = 1'b0;
        end else if (ready_mode == 0) begin
            bus.out_ready = 1'b1;
        end else begin
            bus.out_ready = ready_pat[pat_idx];
            pat_idx = (pat_idx + 1) % 6;
        end
    end

    // Monitor: every valid word is checked against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_low_with_done", int'(bus.busy), 0);
            end
            if (bus.out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", int'(bus.out_data), -1);
                end else begin
                    exp_w = exp_q[0];
                    chk("out_data", int'(bus.out_data), int'(exp_w[7:0]));
                    chk("out_last", int'(bus.out_last), int'(exp_w[8]));
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        hs_total++;
                        last_hs_cyc = cyc;
                        $display("xfer cycle=%0d data=0x%02h last=%0b", cyc, bus.out_data, bus.out_last);
                    end
                end
            end
        end
    end

    task automatic run_burst(input logic [4:0] addr, input logic [5:0] len,
                             input int mode, input int inject, input string tag);
        int acc;
        int t;
        int dc0;
        ready_mode = mode;
        dc0 = done_cnt;
        first_valid_cyc = -1;
        @(posedge clk); #2;
        bus.start = 1'b1;
        bus.start_address = addr;
        bus.burst_len = len;
        @(posedge clk); #2;
        acc = cyc;
        bus.start = 1'b0;
        chk({tag, "_busy_at_accept"}, int'(bus.busy), int'(len != 0));
        t = 0;
        while (done_cnt == dc0 && t < 300) begin
            @(posedge clk); #2;
            t++;
            if (inject > 0 && t == inject) begin
                bus.start = 1'b1;
                bus.start_address = 5'd9;
                bus.burst_len = 6'd5;
            end else begin
                bus.start = 1'b0;
            end
            if (len == 0) chk({tag, "_busy_never"}, int'(bus.busy), 0);
        end
        bus.start = 1'b0;
        chk({tag, "_done_seen"}, done_cnt - dc0, 1);
        repeat (4) @(posedge clk);
        #2;
        chk({tag, "_done_count"}, done_cnt - dc0, 1);
        chk({tag, "_all_words"}, exp_q.size(), 0);
        if (len != 0) begin
            chk({tag, "_first_valid_lat"}, first_valid_cyc - acc, 2);
            chk({tag, "_done_after_last"}, done_cyc - last_hs_cyc, 1);
        end else begin
            chk({tag, "_no_traffic"}, first_valid_cyc, -1);
            chk({tag, "_done_next_cycle"}, done_cyc, acc);
        end
        $display("burst %s start=%0d len=%0d finished at cycle %0d", tag, addr, len, cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int base;
        int dc0;
        for (int i = 0; i < 32; i++) mem[i] = 8'(i) ^ 8'hA0;
        bus.start = 1'b0;
        bus.start_address = '0;
        bus.burst_len = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_last", int'(bus.out_last), 0);
        chk("rst_data", int'(bus.out_data), 0);
        chk("rst_addr", int'(bus.address_read), 0);
        reset = 1'b0;

        push_exp(8'hA3, 0); push_exp(8'hA4, 0); push_exp(8'hA5, 0); push_exp(8'hA6, 1);
        run_burst(5'd3, 6'd4, 0, 0, "basic");

        push_exp(8'hBE, 0); push_exp(8'hBF, 0); push_exp(8'hA0, 0); push_exp(8'hA1, 1);
        run_burst(5'd30, 6'd4, 0, 0, "wrap");

        push_exp(8'hAC, 0); push_exp(8'hAD, 0); push_exp(8'hAE, 0);
        push_exp(8'hAF, 0); push_exp(8'hB0, 0); push_exp(8'hB1, 1);
        run_burst(5'd12, 6'd6, 1, 0, "stall");

        run_burst(5'd4, 6'd0, 0, 0, "zero");

        push_exp(8'hA5, 0); push_exp(8'hA6, 0); push_exp(8'hA7, 1);
        run_burst(5'd5, 6'd3, 0, 2, "ignore");

        // Reset mid-burst after two of eight words.
        for (int i = 8; i < 16; i++) push_exp(8'(i) ^ 8'hA0, i == 15);
        ready_mode = 0;
        base = hs_total;
        dc0 = done_cnt;
        @(posedge clk); #2;
        bus.start = 1'b1; bus.start_address = 5'd8; bus.burst_len = 6'd8;
        @(posedge clk); #2;
        bus.start = 1'b0;
        t = 0;
        while (hs_total < base + 2 && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk("rst_mid_two_words", hs_total - base, 2);
        #2;
        reset = 1'b1;
        rdy_block = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #2;
        exp_q.delete();
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_valid", int'(bus.out_valid), 0);
        chk("mid_rst_last", int'(bus.out_last), 0);
        chk("mid_rst_data", int'(bus.out_data), 0);
        chk("mid_rst_addr", int'(bus.address_read), 0);
        chk("mid_rst_done", int'(bus.done), 0);
        reset = 1'b0;
        rdy_block = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        chk("mid_rst_no_done", done_cnt - dc0, 0);
        push_exp(8'hA0, 0); push_exp(8'hA1, 1);
        run_burst(5'd0, 6'd2, 0, 0, "after_rst");

        for (int i = 0; i < 32; i++) push_exp(8'((i + 7) % 32) ^ 8'hA0, i == 31);
        run_burst(5'd7, 6'd32, 0, 0, "full");

        for (int i = 0; i < 32; i++) push_exp(8'(i) ^ 8'hA0, i == 31);
        run_burst(5'd0, 6'd40, 0, 0, "clamp");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
Read-side master for the team's `ram_new` RAM. It accepts a burst request (start address, length) and drives `address_read`. It captures `data_read`, which the RAM returns one cycle after the address is sampled. The words are delivered, in address order, on a valid/ready stream with full backpressure support. It sits between `ram_new`, with `clk_read` tied to `clk`, and any stream consumer, such as a UART or DMA engine.

Parameters:
- D_WIDTH, 16, data word width; must match the attached RAM.
- A_WIDTH, 4, address width.
- A_MAX, 16, number of RAM words. Legal range is 2..2^A_WIDTH; the address wraps at A_MAX.

Ports:
- clk  in  1  single clock; also drives the RAM's `clk_read`.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only while busy=0.
- start_address  in  A_WIDTH  first address of the burst; must be < A_MAX.
- burst_len  in  A_WIDTH+1  number of words, 0..A_MAX.
- busy  out  1  high from the accepting edge until done.
- done  out  1  one-cycle pulse at the end of the burst.
- address_read  out  A_WIDTH  registered address to the RAM.
- data_read  in  D_WIDTH  RAM read data, valid one clk after the address is sampled.
- out_data  out  D_WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from the consumer.
- out_last  out  1  marks the final word of the burst; qualified by out_valid.

Behaviour:
- Reset (synchronous, active-high): clears the state machine to IDLE and flushes the FIFO.
  - busy=0, done=0, out_valid=0, out_last=0, out_data=0, address_read=0.
  - Both in-flight flags and all counters are cleared.
  - Reset mid-burst aborts immediately: no done pulse, and no stale word appears after reset.
- State machine: IDLE -> ISSUE -> DRAIN -> IDLE.
- IDLE:
  - start=1 with burst_len>0: at edge E0, load address_read<=start_address, set issued flag, set remaining<=burst_len-1, busy<=1, go to ISSUE (or DRAIN if burst_len=1).
  - start=1 with burst_len=0: busy stays 0, done pulses in the next cycle, no stream traffic.
- ISSUE:
  - One read is issued per cycle while credit exists: (fifo_count + inflight) < 4, using registered counts with no same-cycle pop credit.
  - On each issue, address_read <= (address_read==A_MAX-1) ? 0 : address_read+1, and remaining decrements.
  - When the last address is issued, go to DRAIN.
  - address_read holds its value on non-issue cycles.
- Read pipeline:
  - Two-stage in-flight tracking: issued (E0) -> in_ram (E1).
  - At E2, data_read is pushed into the FIFO.
  - First out_valid is therefore high after the edge 2 cycles after acceptance.
  - With out_ready=1 continuously, words stream back-to-back, one per clk.
- FIFO: depth 4, first-word-fall-through; out_valid = FIFO not empty.
  - Push and pop in the same cycle are legal; count is unchanged.
  - The credit rule guarantees the FIFO never overflows. Overflow is an assertion failure in simulation.
- out_last: set on the word whose pop brings the delivered count to burst_len.
- DRAIN: waits until the FIFO is empty and inflight=0 after the last handshake. Then it pulses done for 1 cycle, drops busy in the same cycle, and goes to IDLE.
- start while busy=1 is ignored; it is not queued.
- out_valid, once high, stays high with out_data stable until out_ready=1.
- Width rules:
  - burst_len is A_WIDTH+1 bits so that A_MAX itself is expressible; values > A_MAX are clamped to A_MAX.
  - The address counter is A_WIDTH bits with explicit wrap at A_MAX, independent of 2^A_WIDTH.

Decomposition:
- Package ram_burst_pkg:
  - State enum {IDLE, ISSUE, DRAIN}.
  - Constant FIFO_DEPTH=4.
  - Constant RD_LATENCY=1 (RAM read latency), plus the derived in-flight depth.
- Sub-module burst_fifo: 4-entry synchronous FIFO (D_WIDTH+1 bits including last) with push, pop, count, empty and full. It is reset by the same synchronous reset.

Test Plan (bench: `ram_new` #(8,5,32) with both clocks tied to clk; ram_burst_reader #(8,5,32); memory preloaded with mem[i]=i^8'hA0):
- start_address=3, burst_len=4, out_ready=1 -> out_data A3,A4,A5,A6 on consecutive cycles. First valid is 2 cycles after acceptance, out_last on A6, done one cycle after the last handshake.
- start_address=30, burst_len=4 -> addresses 30,31,0,1; data BE,BF,A0,A1; wrap is correct.
- burst_len=6 with out_ready toggling 1,0,0,1,0,1… -> all 6 words delivered in order with no duplicates or drops. out_data stays stable while stalled, and the FIFO never exceeds 4.
- burst_len=0 -> done pulses once, busy never rises, out_valid stays 0. A start pulse during a busy burst is ignored, and the burst completes unchanged.
- Reset asserted for 1 cycle after 2 of 8 words -> all outputs at reset values the next cycle, and no further out_valid. A new burst start_address=0, burst_len=2 then returns A0,A1.
- burst_len=32 (=A_MAX) with out_ready=1 -> 32 words returned, ending at the address before start_address; exactly one done.
